// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage access controller. Takes the registered MEM-stage request
//   (valid, mem_write, mem_read, addr, wdata) and runs one req/ack
//   transaction on the data-memory bus. It holds the pipeline with stall
//   until the bus responds or the timeout expires.
//
//   Ports
//     clk, rst        : rising-edge clock, asynchronous active-high reset
//     valid           : MEM stage holds a live instruction
//     mem_write       : store request (wins over mem_read)
//     mem_read        : load request
//     addr, wdata     : access address and store data
//     bus_req         : registered bus request, held high for the whole BUSY phase
//     bus_we          : 1 = write, 0 = read (valid while bus_req is high)
//     bus_addr        : registered bus address
//     bus_wdata       : registered bus write data
//     bus_ack         : one-cycle completion from memory
//     bus_rdata       : read data, valid while bus_ack is high
//     stall           : hold upstream pipeline registers
//     rdata_out       : last load result, held between loads
//     rdata_valid     : one-cycle strobe marking a new load result
//     err             : sticky timeout flag, cleared only by rst
module mem_access_unit #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic       access;
  logic       expired;

  assign access  = valid & (mem_write | mem_read);
  // The counter holds the number of BUSY cycles already spent without an ack.
  // The abort therefore happens in the TIMEOUT-th BUSY cycle.
  assign expired = (cnt == CNT_LAST);

  // DONE drops stall so the pipeline advances. The completed instruction is
  // still on the inputs during DONE, so DONE must not start a new access.
  assign stall = ((state == IDLE) & access) | (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access) state_nx = BUSY;
      BUSY:    if (bus_ack || expired) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs and result registers. bus_we doubles as the read/write flag
  // of the access in flight, because it is stable for the whole BUSY phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= addr;
            bus_wdata <= wdata;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            // An ack that arrives in the expiry cycle wins, so err is not set.
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata_out   <= bus_rdata;
              rdata_valid <= 1'b1;
            end
          end else if (expired) begin
            bus_req <= 1'b0;
            err     <= 1'b1;
            if (!bus_we) begin
              rdata_out   <= '0;
              rdata_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access controller.
- Sits directly downstream of the MEM-stage pipeline latch and consumes its registered write-enable, read-enable, address and store data.
- Runs a req/ack transaction against the data-memory bus and stalls the pipeline until the bus responds.
- Presents load data and a one-cycle valid strobe to the writeback latch.

Parameters:
ADDR_W, 11, data-memory address width
DATA_W, 16, data word width
TIMEOUT, 15, max cycles in BUSY without bus_ack before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
valid  in  1  MEM stage holds a live instruction
mem_write  in  1  store request (registered by MEM latch)
mem_read  in  1  load request
addr  in  ADDR_W  access address
wdata  in  DATA_W  store data
bus_req  out  1  bus request, registered
bus_we  out  1  1=write, 0=read; valid while bus_req
bus_addr  out  ADDR_W  bus address, registered
bus_wdata  out  DATA_W  bus write data, registered
bus_ack  in  1  one-cycle completion from memory
bus_rdata  in  DATA_W  read data, valid with bus_ack
stall  out  1  hold upstream pipeline registers
rdata_out  out  DATA_W  last load result, held
rdata_valid  out  1  one-cycle strobe: new load result
err  out  1  sticky timeout flag

Behaviour:
- Single clock domain: clk.
- rst is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, rdata_out, rdata_valid, err, and the timeout counter = 0.
  - stall = 0.
- access = valid & (mem_write | mem_read).
- mem_write and mem_read both high: treated as a write (write wins); no error.
- stall is combinational: (state==IDLE & access) | (state==BUSY). No stall in DONE.
- IDLE:
  - On access, register addr, wdata and we=mem_write onto the bus outputs, set bus_req=1, clear the counter, go to BUSY.
  - Otherwise stay in IDLE with bus_req=0.
- BUSY (bus_req=1, bus outputs stable):
  - bus_ack=1: bus_req->0. If the access is a read, rdata_out<=bus_rdata and rdata_valid<=1. Go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without an ack: bus_req->0, err<=1 (sticky), rdata_out<=0, rdata_valid<=1 if the access is a read, go to DONE.
  - bus_ack and timeout in the same cycle: the ack wins and err is not set.
- DONE:
  - Lasts exactly one cycle; stall=0, so the pipeline advances at the end of this cycle.
  - Inputs still show the completed instruction; they are ignored, with no re-trigger. Go to IDLE unconditionally.
  - rdata_valid returns to 0 the following cycle.
- Latency:
  - Request seen in IDLE at cycle 0; bus_req high from cycle 1.
  - Ack at cycle N gives DONE at N+1; the pipeline is released at the end of N+1.
  - Minimum occupancy is 3 cycles: IDLE, BUSY, DONE.
- bus_ack outside BUSY is ignored.
- rdata_out changes only on a read completion or timeout; it is not affected by writes.
- Reset mid-transaction: bus_req drops immediately (asynchronously); the state is abandoned and no retry occurs.
- Pending ack after reset: the memory's ack for the abandoned transaction, if it still arrives, falls in IDLE and is ignored.
- err clears only on rst.

Test Plan:
- Reset: assert rst mid-BUSY with bus_req=1 -> bus_req=0 within the same cycle; all outputs 0; state IDLE; a subsequent bus_ack is ignored.
- Store: valid=1, mem_write=1, addr=0x005, wdata=0xBEEF; ack 2 cycles after bus_req rises:
  - bus_we=1, bus_addr=0x005, bus_wdata=0xBEEF held stable while bus_req=1.
  - stall high for 4 cycles; rdata_valid never asserts; rdata_out unchanged.
- Load: mem_read=1, addr=0x3FF; ack same cycle after bus_req rises, with bus_rdata=0x1234:
  - rdata_out=0x1234, rdata_valid pulses exactly 1 cycle.
  - stall high 2 cycles, low in DONE.
- Back-to-back: load then store with inputs held through DONE:
  - Exactly two bus transactions occur; no duplicate request in DONE.
  - Second bus_req rises 2 cycles after the first DONE.
- Timeout: load with bus_ack never asserted, TIMEOUT=15:
  - bus_req drops after 15 BUSY cycles; err=1 and stays 1.
  - rdata_out=0, rdata_valid pulses once.
  - A later successful load updates rdata_out while err stays 1.
- Conflicts:
  - mem_write=mem_read=1 -> bus_we=1.
  - valid=0 with mem_read=1 -> no bus_req, stall=0.
  - bus_ack on the same cycle as timeout expiry -> err stays 0, data captured.
